// File: rtl/mdu_ctrl.sv
// mdu_ctrl - multiply/divide sequencer for the E-stage.
//
// Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO commands, owns the HI/LO
// registers and reproduces the fixed multi-cycle latency of the MDU. The
// arithmetic result is computed when the command is accepted and parked in
// pend_hi/pend_lo. It is committed to HI/LO on the last busy cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      E-stage holds a valid MDU command this cycle
//   op         0 MULT,1 MULTU,2 DIV,3 DIVU,4 MFHI,5 MFLO,6 MTHI,7 MTLO
//   rs_data    dividend / multiplicand / MTHI-MTLO source
//   rt_data    divisor / multiplier
//   d_md_use   D-stage instruction is an MDU command
//   busy       registered, operation in flight
//   stall_req  combinational stall request for the D-stage
//   hi, lo     registered HI/LO
//   md_rdata   combinational MFHI/MFLO read data (0 otherwise)
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  // Returns {hi, lo} of the 64-bit product.
  function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    sb = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return sa * sb;
  endfunction

  // Returns {remainder, quotient}. The 33-bit width makes -2^31 / -1 wrap to
  // 0x80000000 without signed overflow. A zero divisor is replaced by 1 only
  // to keep the divider well defined; that result is never committed.
  function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed);
    logic signed [32:0] sa;
    logic signed [32:0] sb;
    logic signed [32:0] q;
    logic signed [32:0] r;
    sa = is_signed ? {a[31], a} : {1'b0, a};
    sb = (b == 32'd0) ? 33'sd1 : (is_signed ? {b[31], b} : {1'b0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = mul_res(rs_data, rt_data, op == OP_MULT);
              pend_wr_d = 1'b1;
              cnt_d     = MULT_CNT;
              busy_d    = 1'b1;
              state_d   = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              {pend_hi_d, pend_lo_d} = div_res(rs_data, rt_data, op == OP_DIV);
              // Divide by zero still occupies the unit but leaves HI/LO alone.
              pend_wr_d = (rt_data != 32'd0);
              cnt_d     = DIV_CNT;
              busy_d    = 1'b1;
              state_d   = BUSY;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Commands arriving while busy are ignored; the stall holds them in D.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d     = 4'd0;
          busy_d    = 1'b0;
          state_d   = IDLE;
          pend_wr_d = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Pending result is pure data; pend_wr_q gates whether it is ever used.
  always_ff @(posedge clk) begin
    pend_hi_q <= pend_hi_d;
    pend_lo_q <= pend_lo_d;
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  // Raised in the start cycle too, so an MFHI/MFLO right behind a mult/div waits.
  assign stall_req = d_md_use & (busy_q | (start & (op <= OP_DIVU)));
  assign md_rdata  = (start && op == OP_MFHI) ? hi_q :
                     (start && op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: scoreboard of expected {hi,lo} per mult/div command.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .d_md_use(d_md_use),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .md_rdata(md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle. Drives one mult/div
  // command, follows the busy window and compares HI/LO with the scoreboard.
  // Returns just after the negedge of the first non-busy cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int cycles, input logic use_d,
                        input logic [63:0] exp);
    int n;
    logic [63:0] old;
    logic [63:0] want;
    old      = {hi, lo};
    start    = 1'b1;
    op       = o;
    rs_data  = a;
    rt_data  = b;
    d_md_use = use_d;
    exp_q.push_back(exp);
    #1;
    check({tag, "_stall_start"}, 64'(stall_req), 64'(use_d));
    @(negedge clk);
    start = 1'b0;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      check({tag, "_hold"}, {hi, lo}, old);
      check({tag, "_stall_busy"}, 64'(stall_req), 64'(use_d));
      @(negedge clk);
      #1;
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(cycles));
    check({tag, "_stall_after"}, 64'(stall_req), 64'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      want = exp_q.pop_front();
      check({tag, "_hilo"}, {hi, lo}, want);
    end
    d_md_use = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset    = 1'b0;
    start    = 1'b0;
    op       = 3'd0;
    rs_data  = 32'd0;
    rt_data  = 32'd0;
    d_md_use = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_rdata", 64'(md_rdata), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    #1;

    run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 5, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
    // Back-to-back: starts in the first cycle after busy falls.
    run_op("divu", 3'd3, 32'd100, 32'd7, 10, 1'b0, {32'd2, 32'd14});
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, {32'd0, 32'h8000_0000});

    // MTHI / MTLO / MFHI
    start = 1'b1; op = 3'd6; rs_data = 32'h1234_5678;
    @(negedge clk);
    op = 3'd7; rs_data = 32'h9ABC_DEF0;
    #1;
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    op = 3'd4;
    #1;
    check("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mfhi_rdata", 64'(md_rdata), 64'h1234_5678);
    op = 3'd5;
    #1;
    check("mflo_rdata", 64'(md_rdata), 64'h9ABC_DEF0);
    start = 1'b0;
    #1;
    check("rdata_idle", 64'(md_rdata), 64'd0);

    // Divide by zero keeps hi=5, lo=9.
    @(negedge clk);
    start = 1'b1; op = 3'd6; rs_data = 32'd5;
    @(negedge clk);
    op = 3'd7; rs_data = 32'd9;
    @(negedge clk);
    start = 1'b0;
    #1;
    run_op("div0", 3'd2, 32'd77, 32'd0, 10, 1'b0, {32'd5, 32'd9});

    // MULTU with an MFHI waiting in D.
    run_op("multu_stall", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1, 64'hFFFF_FFFE_0000_0001);
    start = 1'b1; op = 3'd4;
    #1;
    check("mfhi_after", 64'(md_rdata), 64'hFFFF_FFFE);
    start = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      a = $urandom();
      b = $urandom();
      run_op("rnd_multu", 3'd1, a, b, 5, 1'b0, {32'd0, a} * {32'd0, b});
      b = b | 32'd1;
      run_op("rnd_divu", 3'd3, a, b, 10, 1'b0, {a % b, a / b});
    end

    // Reset in busy cycle 3 of a DIVU.
    start = 1'b1; op = 3'd6; rs_data = 32'hDEAD_BEEF;
    @(negedge clk);
    op = 3'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rstmid_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      check("rstmid_no_late_write", {hi, lo, 31'd0, busy}, 96'd0);
    end
    run_op("mult_after_rst", 3'd0, 32'd6, 32'd7, 5, 1'b0, {32'd0, 32'd42});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
